emin_sweep_engine: RTL and testbench

// Pipelined successor to the single-i Emin stage; sits between T_bram and the Emin buffer writer.
// On start with index i: fetches T(nu,i) for all NU_VALUES channels, then sweeps j = 0..i-1.
// For each j it emits the cost E(j,i) = sum over nu of dist(T(nu,i), T(nu,j)).

---
 rtl/emin_sweep_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_emin_sweep_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emin_sweep_engine.sv
// emin_sweep_engine
// Computes E(j,i) = sum over nu of dist(T(nu,i), T(nu,j)) for j = 0..i-1.
// It fetches row i once, then issues one T read per cycle. It tracks the
// running minimum and its argmin, and reports both with a done pulse.
// Optional feature: define EMIN_SQ_DIST_EN to use the squared difference as
// the distance. This adds one pipeline stage in front of the channel sum.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a start, T_req parked at 0
// ST_FETCH | T_req = i, waiting READ_LAT cycles for row Ti
// ST_SWEEP | issuing T_req = 0..i-1, one per cycle
// ST_DRAIN | issue finished, waiting for the last cost to emerge
// ST_DONE  | one-cycle done pulse, min_data/min_j published
module emin_sweep_engine #(
    parameter int BIT_WIDTH  = 32,
    parameter int I          = 160,
    parameter int NU_VALUES  = 3,
    parameter int READ_LAT   = 2,
    localparam int IW        = $clog2(I)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [IW-1:0]                  i,
    input  logic                           input_valid,
    input  logic [NU_VALUES*BIT_WIDTH-1:0] T_resp,
    output logic [IW-1:0]                  T_req,
    output logic [IW-1:0]                  j,
    output logic [BIT_WIDTH-1:0]           data,
    output logic                           output_valid,
    output logic                           busy,
    output logic                           done,
    output logic [BIT_WIDTH-1:0]           min_data,
    output logic [IW-1:0]                  min_j
);

    // The channel sum keeps enough headroom that saturation is a simple
    // test of the bits above BIT_WIDTH.
    localparam int SW = BIT_WIDTH + $clog2(NU_VALUES) + 1;
    localparam int WW = $clog2(READ_LAT + 1);
    localparam logic [IW-1:0] I_LAST = IW'(I - 1);
    localparam logic [IW-1:0] ONE    = IW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                         state;
    logic [IW-1:0]                  i_lat;
    logic [NU_VALUES*BIT_WIDTH-1:0] ti_row;
    logic [WW-1:0]                  wait_cnt;
    logic                           req_v;

    logic [READ_LAT-1:0]            dl_v;
    logic [IW-1:0]                  dl_j   [READ_LAT];
    logic [BIT_WIDTH-1:0]           diff_c [NU_VALUES];

    logic                           a_v;
    logic [IW-1:0]                  a_j;
    logic [BIT_WIDTH-1:0]           a_dist [NU_VALUES];

    logic                           s_v;
    logic [IW-1:0]                  s_j;
    logic [BIT_WIDTH-1:0]           s_dist [NU_VALUES];

    logic [SW-1:0]                  sum_c;
    logic [BIT_WIDTH-1:0]           cost_c;
    logic [BIT_WIDTH-1:0]           run_min;
    logic [IW-1:0]                  run_j;
    logic                           pipe_busy;
    logic [IW-1:0]                  i_cl;

    assign i_cl = (i > I_LAST) ? I_LAST : i;

    // Per-channel absolute difference between row i and the returning row j.
    always_comb begin
        for (int n = 0; n < NU_VALUES; n++) begin
            if (ti_row[n*BIT_WIDTH +: BIT_WIDTH] >= T_resp[n*BIT_WIDTH +: BIT_WIDTH])
                diff_c[n] = ti_row[n*BIT_WIDTH +: BIT_WIDTH] - T_resp[n*BIT_WIDTH +: BIT_WIDTH];
            else
                diff_c[n] = T_resp[n*BIT_WIDTH +: BIT_WIDTH] - ti_row[n*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    // j tag delay line that matches the T_bram latency, then stage A (distance).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dl_v <= '0;
            a_v  <= 1'b0;
            a_j  <= '0;
            for (int k = 0; k < READ_LAT; k++) dl_j[k] <= '0;
            for (int n = 0; n < NU_VALUES; n++) a_dist[n] <= '0;
        end else begin
            dl_v[0] <= req_v;
            dl_j[0] <= T_req;
            for (int k = 1; k < READ_LAT; k++) begin
                dl_v[k] <= dl_v[k-1];
                dl_j[k] <= dl_j[k-1];
            end
            a_v <= dl_v[READ_LAT-1];
            a_j <= dl_j[READ_LAT-1];
            for (int n = 0; n < NU_VALUES; n++) a_dist[n] <= diff_c[n];
        end
    end

`ifdef EMIN_SQ_DIST_EN
    logic                 q_v;
    logic [IW-1:0]        q_j;
    logic [BIT_WIDTH-1:0] q_dist [NU_VALUES];

    function automatic logic [BIT_WIDTH-1:0] sq_sat(input logic [BIT_WIDTH-1:0] d);
        logic [2*BIT_WIDTH-1:0] p;
        p = {{BIT_WIDTH{1'b0}}, d} * {{BIT_WIDTH{1'b0}}, d};
        if (p[2*BIT_WIDTH-1:BIT_WIDTH] != '0)
            sq_sat = '1;
        else
            sq_sat = p[BIT_WIDTH-1:0];
    endfunction

    // Extra stage: square each difference at full width, clamp to BIT_WIDTH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            q_v <= 1'b0;
            q_j <= '0;
            for (int n = 0; n < NU_VALUES; n++) q_dist[n] <= '0;
        end else begin
            q_v <= a_v;
            q_j <= a_j;
            for (int n = 0; n < NU_VALUES; n++) q_dist[n] <= sq_sat(a_dist[n]);
        end
    end

    // Feed the summing stage from the squaring stage.
    always_comb begin
        s_v = q_v;
        s_j = q_j;
        for (int n = 0; n < NU_VALUES; n++) s_dist[n] = q_dist[n];
    end

    assign pipe_busy = req_v | (|dl_v) | a_v | q_v;
`else
    // Feed the summing stage directly from the distance stage.
    always_comb begin
        s_v = a_v;
        s_j = a_j;
        for (int n = 0; n < NU_VALUES; n++) s_dist[n] = a_dist[n];
    end

    assign pipe_busy = req_v | (|dl_v) | a_v;
`endif

    // Channel sum with saturation to all-ones.
    always_comb begin
        sum_c = '0;
        for (int n = 0; n < NU_VALUES; n++) sum_c = sum_c + SW'(s_dist[n]);
        if (sum_c[SW-1:BIT_WIDTH] != '0)
            cost_c = '1;
        else
            cost_c = sum_c[BIT_WIDTH-1:0];
    end

    // Sequencing FSM, stage B output register and running minimum.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= ST_IDLE;
            i_lat        <= '0;
            ti_row       <= '0;
            wait_cnt     <= '0;
            req_v        <= 1'b0;
            T_req        <= '0;
            j            <= '0;
            data         <= '0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            min_data     <= '0;
            min_j        <= '0;
            run_min      <= '0;
            run_j        <= '0;
        end else begin
            output_valid <= s_v;
            done         <= 1'b0;
            if (s_v) begin
                data <= cost_c;
                j    <= s_j;
                // Strict compare: on a tie the earlier (lower) j is kept.
                if (cost_c < run_min) begin
                    run_min <= cost_c;
                    run_j   <= s_j;
                end
            end

            case (state)
                ST_IDLE: begin
                    T_req <= '0;
                    if (input_valid) begin
                        i_lat    <= i_cl;
                        T_req    <= i_cl;
                        wait_cnt <= WW'(READ_LAT);
                        busy     <= 1'b1;
                        run_min  <= '1;
                        run_j    <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (wait_cnt == '0) begin
                        ti_row <= T_resp;
                        if (i_lat == '0) begin
                            done     <= 1'b1;
                            min_data <= run_min;
                            min_j    <= run_j;
                            state    <= ST_DONE;
                        end else begin
                            T_req <= '0;
                            req_v <= 1'b1;
                            state <= ST_SWEEP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                ST_SWEEP: begin
                    if (T_req == i_lat - ONE) begin
                        T_req <= '0;
                        req_v <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        T_req <= T_req + ONE;
                    end
                end
                ST_DRAIN: begin
                    // Final cost is on the output this cycle and nothing else is in flight.
                    if (output_valid && !pipe_busy) begin
                        done     <= 1'b1;
                        min_data <= run_min;
                        min_j    <= run_j;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emin_sweep_engine.sv
// Bench for emin_sweep_engine: T_bram model, reference cost model, directed
// vector table, hand-written multi-cycle sequences and randomized sweeps.
module tb_emin_sweep_engine;
    localparam int BW    = 32;
    localparam int DEPTH = 160;
    localparam int NU    = 3;
    localparam int RL    = 2;
    localparam int IW    = $clog2(DEPTH);
`ifdef EMIN_SQ_DIST_EN
    localparam int LAT = RL + 3;
`else
    localparam int LAT = RL + 2;
`endif
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic [IW-1:0]   i = '0;
    logic            input_valid = 1'b0;
    logic [NU*BW-1:0] T_resp;
    logic [IW-1:0]   T_req, j, min_j;
    logic [BW-1:0]   data, min_data;
    logic            output_valid, busy, done;

    emin_sweep_engine #(.BIT_WIDTH(BW), .I(DEPTH), .NU_VALUES(NU), .READ_LAT(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .i(i), .input_valid(input_valid),
        .T_resp(T_resp), .T_req(T_req), .j(j), .data(data),
        .output_valid(output_valid), .busy(busy), .done(done),
        .min_data(min_data), .min_j(min_j)
    );

    always #5 clk_in = ~clk_in;

    // T_bram model: row addressed by T_req appears RL cycles later.
    logic [BW-1:0] tmem [256][NU];
    logic [IW-1:0] rq [RL];
    always @(posedge clk_in) begin
        rq[0] <= T_req;
        for (int k = 1; k < RL; k++) rq[k] <= rq[k-1];
    end
    always_comb begin
        T_resp = '0;
        for (int n = 0; n < NU; n++) T_resp[n*BW +: BW] = tmem[rq[RL-1]][n];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc     = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // Output monitor: records every emitted cost and the done pulse.
    logic [IW-1:0] out_j [$];
    logic [BW-1:0] out_d [$];
    int            out_c [$];
    int            done_n = 0;
    int            done_c = 0;
    logic [BW-1:0] done_min;
    logic [IW-1:0] done_minj;
    logic [IW-1:0] hist [64];
    always @(negedge clk_in) begin
        if (output_valid) begin
            chk("latency_from_treq", 64'(hist[(cyc - LAT) & 63]), 64'(j));
            out_j.push_back(j);
            out_d.push_back(data);
            out_c.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_c    = cyc;
            done_min  = min_data;
            done_minj = min_j;
        end
        hist[cyc & 63] = T_req;
    end

    // Reference model: cost computed straight from the distance definition.
    logic [BW-1:0] exp_d [$];
    logic [BW-1:0] exp_min;
    int            exp_minj;

    function automatic logic [BW-1:0] ref_cost(int ii, int jj);
        longint unsigned s, a, b, d;
        s = 0;
        for (int n = 0; n < NU; n++) begin
            a = 64'(tmem[ii][n]);
            b = 64'(tmem[jj][n]);
            d = (a > b) ? a - b : b - a;
`ifdef EMIN_SQ_DIST_EN
            d = d * d;
            if (d > MAXV) d = MAXV;
`endif
            s = s + d;
        end
        if (s > MAXV) s = MAXV;
        return s[BW-1:0];
    endfunction

    task automatic ref_sweep(input int ii);
        logic [BW-1:0] c;
        exp_d.delete();
        exp_min  = '1;
        exp_minj = 0;
        for (int jj = 0; jj < ii; jj++) begin
            c = ref_cost(ii, jj);
            exp_d.push_back(c);
            if (c < exp_min) begin
                exp_min  = c;
                exp_minj = jj;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_T_req"}, 64'(T_req), 0);
        chk({tag, "_j"}, 64'(j), 0);
        chk({tag, "_data"}, 64'(data), 0);
        chk({tag, "_output_valid"}, 64'(output_valid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_min_data"}, 64'(min_data), 0);
        chk({tag, "_min_j"}, 64'(min_j), 0);
    endtask

    // Start a sweep, optionally poke a stray start mid-flight, wait for done
    // and compare everything against the reference model.
    task automatic run_case(input string tag, input int i_in, input int inject_at);
        int ie;
        int k;
        ie = (i_in > DEPTH - 1) ? DEPTH - 1 : i_in;
        ref_sweep(ie);
        out_j.delete(); out_d.delete(); out_c.delete();
        done_n = 0;
        i = IW'(i_in);
        input_valid = 1'b1;
        acc = cyc + 1;
        step();
        input_valid = 1'b0;
        i = '0;
        chk({tag, "_busy_at_start"}, 64'(busy), 1);
        if (inject_at >= 0) begin
            repeat (inject_at) step();
            i = IW'(9);
            input_valid = 1'b1;
            step();
            input_valid = 1'b0;
            i = '0;
        end
        k = 0;
        while (done_n == 0 && k < ie + 40) begin
            step();
            k++;
        end
        if (done_n == 0) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_busy_during_done"}, 64'(busy), 1);
            step();
            chk({tag, "_busy_done_after"}, 64'({busy, done}), 0);
        end
        chk({tag, "_out_count"}, 64'(out_j.size()), 64'(ie));
        for (int n = 0; n < out_j.size() && n < ie; n++) begin
            chk({tag, "_j_seq"}, 64'(out_j[n]), 64'(n));
            chk({tag, "_data"}, 64'(out_d[n]), 64'(exp_d[n]));
        end
        chk({tag, "_done_count"}, 64'(done_n), 1);
        if (ie == 0)
            chk({tag, "_done_time"}, 64'(done_c), 64'(acc + RL + 1));
        else if (out_c.size() > 0)
            chk({tag, "_done_time"}, 64'(done_c), 64'(out_c[out_c.size()-1] + 1));
        chk({tag, "_min_data"}, 64'(done_min), 64'(exp_min));
        chk({tag, "_min_j"}, 64'(done_minj), 64'(exp_minj));
        chk({tag, "_min_held"}, 64'(min_data), 64'(exp_min));
    endtask

    task automatic set_row(input int r, input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [BW-1:0] c);
        tmem[r][0] = a;
        tmem[r][1] = b;
        tmem[r][2] = c;
    endtask

    task automatic load_pattern(input int pat);
        for (int r = 0; r < DEPTH; r++) set_row(r, 0, 0, 0);
        case (pat)
            1: begin
                set_row(4, 10, 20, 30);
                set_row(0, 10, 20, 30);
                set_row(2, 15, 20, 25);
                set_row(3, 12, 18, 30);
            end
            2: set_row(0, 5, 5, 5);
            3: begin
                set_row(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                set_row(1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
            end
            4: begin
                for (int r = 0; r < 5; r++) set_row(r, 100, 0, 0);
                set_row(1, 7, 0, 0);
                set_row(3, 0, 0, 7);
            end
            5: begin
                for (int r = 0; r < DEPTH - 1; r++) set_row(r, 50, 50, 50);
                set_row(77, 10, 50, 50);
            end
            6: set_row(1, 32'h8000_0000, 32'h8000_0000, 0);
            default: ;
        endcase
    endtask

    typedef struct {
        int              i_in;
        int              pat;
        int              exp_n;
        logic [BW-1:0]   exp_min;
        int              exp_minj;
        int              n_d;
        logic [3:0][BW-1:0] d;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 256; r++)
            for (int n = 0; n < NU; n++)
                tmem[r][n] = (r >= DEPTH) ? 32'hDEAD_0000 + 32'(r) : '0;

`ifdef EMIN_SQ_DIST_EN
        vecs[0] = '{4, 1, 4, 32'd0, 0, 4, {32'd8, 32'd50, 32'd1400, 32'd0}};
        vecs[3] = '{5, 4, 5, 32'd49, 1, 0, '0};
        vecs[4] = '{200, 5, 159, 32'd5100, 77, 0, '0};
`else
        vecs[0] = '{4, 1, 4, 32'd0, 0, 4, {32'd4, 32'd10, 32'd60, 32'd0}};
        vecs[3] = '{5, 4, 5, 32'd7, 1, 0, '0};
        vecs[4] = '{200, 5, 159, 32'd110, 77, 0, '0};
`endif
        vecs[1] = '{0, 2, 0, 32'hFFFF_FFFF, 0, 0, '0};
        vecs[2] = '{2, 3, 2, 32'hFFFF_FFFF, 0, 2, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}};
        vecs[5] = '{1, 6, 1, 32'hFFFF_FFFF, 0, 1, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}};

        rst_in = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_in = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            load_pattern(vecs[v].pat);
            run_case($sformatf("vec%0d", v), vecs[v].i_in, -1);
            chk($sformatf("vec%0d_hand_count", v), 64'(out_j.size()), 64'(vecs[v].exp_n));
            chk($sformatf("vec%0d_hand_min", v), 64'(done_min), 64'(vecs[v].exp_min));
            chk($sformatf("vec%0d_hand_minj", v), 64'(done_minj), 64'(vecs[v].exp_minj));
            for (int k = 0; k < vecs[v].n_d && k < out_d.size(); k++)
                chk($sformatf("vec%0d_hand_data%0d", v, k), 64'(out_d[k]), 64'(vecs[v].d[k]));
        end

        // Stray start with i=9 during the sweep of i=6 must be ignored.
        for (int r = 0; r < DEPTH; r++) set_row(r, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
        run_case("busy_ignore", 6, 5);

        // Reset in the middle of a sweep aborts it.
        i = IW'(20);
        input_valid = 1'b1;
        step();
        input_valid = 1'b0;
        i = '0;
        repeat (8) step();
        rst_in = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step();
        step();
        rst_in = 1'b1;
        out_j.delete(); out_d.delete(); out_c.delete();
        done_n = 0;
        repeat (30) step();
        chk("rst_mid_no_outputs", 64'(out_j.size()), 0);
        chk("rst_mid_no_done", 64'(done_n), 0);
        run_case("post_rst", 3, -1);

        // Back-to-back: second start lands in the first cycle busy is low.
        load_pattern(1);
        run_case("b2b_a", 4, -1);
        set_row(2, 100, 100, 100);
        run_case("b2b_b", 2, -1);

        // Randomized sweeps against the reference model.
        for (int it = 0; it < 12; it++) begin
            int ii;
            for (int r = 0; r < DEPTH; r++)
                for (int n = 0; n < NU; n++)
                    case (it % 3)
                        0: tmem[r][n] = 32'($urandom_range(0, 7));
                        1: tmem[r][n] = $urandom;
                        default: tmem[r][n] = 32'($urandom_range(0, 1000));
                    endcase
            if (it == 11)
                ii = $urandom_range(160, 255);
            else if ($urandom_range(0, 9) == 0)
                ii = 0;
            else
                ii = $urandom_range(1, 24);
            run_case($sformatf("rand%0d", it), ii, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
